project_vertices: RTL and testbench
===================================

Name: project_vertices

Overview:
Parametrised successor to the single-triangle projector. It transforms NUM_VERTS object-space vertices through one precombined MVP matrix, then applies the clip test, perspective divide and viewport mapping. The block is self-contained, with an internal row-serial MAC and an internal restoring reciprocal divider, and gives fixed, documented latency. It sits between the mesh fetch stage and the rasteriser.

Parameters:
COORD_WIDTH, 32, total bits of signed fixed-point words.
FRAC_BITS, 16, fractional bits; ONE = 1<<FRAC_BITS.
NUM_VERTS, 3, vertices per primitive (>=3).
FB_WIDTH, 320, framebuffer width in pixels.
FB_HEIGHT, 180, framebuffer height in pixels.

Ports:
clk_in  in  1  clock.
rst_n_in  in  1  asynchronous active-low reset.
start  in  1  one-cycle request; accepted only when busy=0.
verts_in  in  NUM_VERTS*3*COORD_WIDTH  object xyz per vertex (w=ONE implied).
mvp_in  in  16*COORD_WIDTH  row-major 4x4 MVP matrix.
screen_out  out  NUM_VERTS*4*COORD_WIDTH  per vertex {inv_w, z, y, x}.
clip_mask  out  NUM_VERTS  bit i=1 means vertex i outside frustum.
prim_valid  out  1  primitive fully visible (and not culled).
busy  out  1  high from accepting start until done.
done  out  1  one-cycle completion pulse.

Behaviour:
- Reset (async, rst_n_in=0): state IDLE; screen_out, clip_mask, prim_valid, busy, done, vertex index, and divider/MAC registers all 0. Reset asserted mid-operation aborts immediately; no done is issued.
- Start accepted in IDLE: verts_in and mvp_in are latched, busy=1 the next cycle, and screen_out/clip_mask are cleared. start while busy is ignored; it is neither queued nor a restart.
- States: IDLE -> LOAD -> MAC -> CLIP -> DIV -> NDC -> VIEW -> STORE -> (LOAD for next vertex | DONE) -> IDLE.
- LOAD (1 cycle): selects vertex i and forms {ONE, z, y, x}.
- MAC (4 cycles): one matrix row per cycle. Row sum = 4 signed 2W-bit products summed; result = sum[FRAC_BITS +: COORD_WIDTH] (arithmetic truncation, no saturation).
- CLIP (1 cycle): vertex is clipped if w<=0 or |x|>w or |y|>w or |z|>w (|v|=w is inside). If clipped: set clip_mask[i], write 0 to screen_out[i], go directly to STORE.
- DIV (exactly COORD_WIDTH cycles): unsigned restoring divide, inv_w = (1<<(2*FRAC_BITS))/w, truncated. If the quotient exceeds the signed max, saturate to 2^(COORD_WIDTH-1)-1.
- NDC (1): ndc_c = (clip_c*inv_w)>>>FRAC_BITS for x, y, z.
- VIEW (1):
  - x = ((ndc_x+ONE)*(FB_WIDTH/2)).
  - y = ((ONE-ndc_y)*(FB_HEIGHT/2)).
  - z = (ndc_z+ONE)>>>1, mapping depth to [0, ONE].
  - All results are fixed-point Q format. Integer multiplies by the half-dimension constants keep the low COORD_WIDTH bits.
- STORE (1): writes screen_out[i]; i++ if i<NUM_VERTS-1, else DONE.
- Per-vertex latency: visible vertex = COORD_WIDTH+9 cycles; clipped vertex = 7 cycles.
- DONE (1 cycle): done=1, busy=0 at the same edge, prim_valid = ~|clip_mask (AND not culled if the option is enabled).
- Every vertex is always processed, so clip_mask is complete; this differs from early-abort behaviour.
- Outputs hold stable from done until the next accepted start.
- start asserted in the DONE cycle is ignored; start is accepted from IDLE, one cycle later.

Optional Feature:
Macro PROJECT_VERTICES_BACKFACE_CULL_EN.
- Defined: adds a CULL state (2 cycles: products, then compare) between the last STORE and DONE. It computes the signed area A = (x1-x0)*(y2-y0) - (x2-x0)*(y1-y0) from screen vertices 0..2. If A>=0 (clockwise in screen space, or degenerate), prim_valid=0. CULL is skipped when any of vertices 0..2 is clipped.
- Undefined: no CULL state; prim_valid depends only on clip_mask; latency exactly as above.

Test Plan:
- Identity MVP, v0=(0,0,0) -> screen_out[0] = {0x00010000, 0x00008000, 0x005A0000, 0x00A00000}; done exactly 3*(41)+1=124 cycles after start with all three vertices visible.
- Identity MVP, v1=(1,1,0) -> x=0x01400000, y=0x00000000, z=0x00008000, clip_mask[1]=0.
- Identity MVP, v2=(2,0,0) -> clip_mask=3'b100, screen_out[2]=0, prim_valid=0; done at 2*41+7+1=90 cycles.
- MVP = identity rows 0-2, row3 = (0,0,-1,0), v=(1,0,-2) -> clip=(1,0,-2,2), inv_w=0x8000, x=0x00F00000, y=0x005A0000, z=0.
- Second start pulsed 10 cycles after the first -> ignored, single done. rst_n_in low mid-DIV -> busy=0 and all outputs 0 immediately; no done.
- With PROJECT_VERTICES_BACKFACE_CULL_EN, CCW triangle (0,0,0),(1,0,0),(0,1,0) under identity -> screen A<0, prim_valid=1. Swapped vertex order -> prim_valid=0.

Source files
------------

// File: rtl/project_vertices.sv
`default_nettype none
// ============================================================================
//  Module   : project_vertices
//  Purpose  : MVP transform, clip test, perspective divide and viewport map for
//             NUM_VERTS vertices using a row-serial MAC and a restoring divider.
//  Option   : PROJECT_VERTICES_BACKFACE_CULL_EN adds a screen-space area cull.
//  Revision : 1.0
// ============================================================================
module project_vertices #(
  parameter int COORD_WIDTH = 32,
  parameter int FRAC_BITS   = 16,
  parameter int NUM_VERTS   = 3,
  parameter int FB_WIDTH    = 320,
  parameter int FB_HEIGHT   = 180
) (
  input  logic                               clk_in,
  input  logic                               rst_n_in,
  input  logic                               start,
  input  logic [NUM_VERTS*3*COORD_WIDTH-1:0] verts_in,
  input  logic [16*COORD_WIDTH-1:0]          mvp_in,
  output logic [NUM_VERTS*4*COORD_WIDTH-1:0] screen_out,
  output logic [NUM_VERTS-1:0]               clip_mask,
  output logic                               prim_valid,
  output logic                               busy,
  output logic                               done
);
  localparam int c_W  = COORD_WIDTH;
  localparam int c_F  = FRAC_BITS;
  localparam int c_IW = $clog2(NUM_VERTS);
  localparam int c_CW = $clog2(COORD_WIDTH);
  localparam logic signed [c_W-1:0] c_ONE   = {{(c_W-1){1'b0}}, 1'b1} << c_F;
  localparam logic signed [c_W-1:0] c_SMAX  = {1'b0, {(c_W-1){1'b1}}};
  localparam logic signed [c_W-1:0] c_HALFW = c_W'(FB_WIDTH / 2);
  localparam logic signed [c_W-1:0] c_HALFH = c_W'(FB_HEIGHT / 2);
  localparam logic [2*c_W-1:0]      c_DIVIDEND = {{(2*c_W-1){1'b0}}, 1'b1} << (2*c_F);
  localparam logic [c_W-1:0]        c_DHI = c_DIVIDEND[2*c_W-1 -: c_W];
  localparam logic [c_W-1:0]        c_DLO = c_DIVIDEND[c_W-1:0];
  localparam logic [c_IW-1:0]       c_LAST = c_IW'(NUM_VERTS - 1);
  localparam logic [c_CW-1:0]       c_CNT_LAST = c_CW'(c_W - 1);

  localparam logic [3:0] c_ST_IDLE  = 4'd0;
  localparam logic [3:0] c_ST_LOAD  = 4'd1;
  localparam logic [3:0] c_ST_MAC   = 4'd2;
  localparam logic [3:0] c_ST_CLIP  = 4'd3;
  localparam logic [3:0] c_ST_DIV   = 4'd4;
  localparam logic [3:0] c_ST_NDC   = 4'd5;
  localparam logic [3:0] c_ST_VIEW  = 4'd6;
  localparam logic [3:0] c_ST_STORE = 4'd7;
  localparam logic [3:0] c_ST_DONE  = 4'd8;
`ifdef PROJECT_VERTICES_BACKFACE_CULL_EN
  localparam logic [3:0] c_ST_CULL0 = 4'd9;
  localparam logic [3:0] c_ST_CULL1 = 4'd10;
`endif

  logic [3:0]                      r_state;
  logic [NUM_VERTS*3*c_W-1:0]      r_verts;
  logic [16*c_W-1:0]               r_mvp;
  logic signed [c_W-1:0]           r_vec [4];
  logic signed [c_W-1:0]           r_clip [4];
  logic [1:0]                      r_row;
  logic [c_IW-1:0]                 r_idx;
  logic [c_CW-1:0]                 r_cnt;
  logic [c_W-1:0]                  r_rem, r_quo, r_dlo;
  logic                            r_ovf;
  logic signed [c_W-1:0]           r_invw, r_nx, r_ny, r_nz, r_sx, r_sy, r_sz;

  // One matrix row against the homogeneous vector, truncated back to Q format.
  logic signed [2*c_W-1:0] w_sum;
  logic signed [c_W-1:0]   w_row;
  always_comb begin
    w_sum = '0;
    for (int c = 0; c < 4; c++) begin
      w_sum = w_sum + $signed(r_mvp[(int'(r_row)*4 + c)*c_W +: c_W]) * r_vec[c];
    end
  end
  assign w_row = c_W'(w_sum >>> c_F);

  logic signed [c_W:0] w_ax, w_ay, w_az, w_aw;
  logic                w_clipped;
  assign w_ax = {r_clip[0][c_W-1], r_clip[0]};
  assign w_ay = {r_clip[1][c_W-1], r_clip[1]};
  assign w_az = {r_clip[2][c_W-1], r_clip[2]};
  assign w_aw = {r_clip[3][c_W-1], r_clip[3]};
  assign w_clipped = r_clip[3][c_W-1] | (r_clip[3] == '0) |
                     (w_ax > w_aw) | (-w_ax > w_aw) |
                     (w_ay > w_aw) | (-w_ay > w_aw) |
                     (w_az > w_aw) | (-w_az > w_aw);

  // Dividend bits above the quotient width are preloaded into the remainder;
  // if that alone reaches w the quotient cannot fit and is saturated.
  logic [c_W:0]          w_rem_sh, w_dvs, w_rem_sub;
  logic                  w_ge;
  logic [c_W-1:0]        w_rem_nx;
  logic signed [c_W-1:0] w_invw;
  assign w_rem_sh  = {r_rem, r_dlo[c_W-1]};
  assign w_dvs     = {1'b0, r_clip[3]};
  assign w_ge      = w_rem_sh >= w_dvs;
  assign w_rem_sub = w_rem_sh - w_dvs;
  assign w_rem_nx  = w_ge ? c_W'(w_rem_sub) : c_W'(w_rem_sh);
  assign w_invw    = (r_ovf | r_quo[c_W-1]) ? c_SMAX : $signed(r_quo);

  logic signed [2*c_W-1:0] w_px, w_py, w_pz;
  logic signed [c_W-1:0]   w_vx, w_vy, w_vz;
  assign w_px = r_clip[0] * w_invw;
  assign w_py = r_clip[1] * w_invw;
  assign w_pz = r_clip[2] * w_invw;
  assign w_vx = (r_nx + c_ONE) * c_HALFW;
  assign w_vy = (c_ONE - r_ny) * c_HALFH;
  assign w_vz = (r_nz + c_ONE) >>> 1;

`ifdef PROJECT_VERTICES_BACKFACE_CULL_EN
  logic signed [c_W:0]     w_dx1, w_dy1, w_dx2, w_dy2;
  logic signed [2*c_W+1:0] r_p1, r_p2;
  assign w_dx1 = $signed(screen_out[4*c_W +: c_W])     - $signed(screen_out[0 +: c_W]);
  assign w_dy1 = $signed(screen_out[5*c_W +: c_W])     - $signed(screen_out[c_W +: c_W]);
  assign w_dx2 = $signed(screen_out[8*c_W +: c_W])     - $signed(screen_out[0 +: c_W]);
  assign w_dy2 = $signed(screen_out[9*c_W +: c_W])     - $signed(screen_out[c_W +: c_W]);
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_p1 <= '0;
      r_p2 <= '0;
    end else if (r_state == c_ST_CULL0) begin
      r_p1 <= w_dx1 * w_dy2;
      r_p2 <= w_dx2 * w_dy1;
    end
  end
`endif

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state    <= c_ST_IDLE;
      r_verts    <= '0;
      r_mvp      <= '0;
      for (int k = 0; k < 4; k++) begin
        r_vec[k]  <= '0;
        r_clip[k] <= '0;
      end
      r_row      <= '0;
      r_idx      <= '0;
      r_cnt      <= '0;
      r_rem      <= '0;
      r_quo      <= '0;
      r_dlo      <= '0;
      r_ovf      <= 1'b0;
      r_invw     <= '0;
      r_nx       <= '0;
      r_ny       <= '0;
      r_nz       <= '0;
      r_sx       <= '0;
      r_sy       <= '0;
      r_sz       <= '0;
      screen_out <= '0;
      clip_mask  <= '0;
      prim_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        c_ST_IDLE: if (start) begin
          r_verts    <= verts_in;
          r_mvp      <= mvp_in;
          screen_out <= '0;
          clip_mask  <= '0;
          prim_valid <= 1'b0;
          busy       <= 1'b1;
          r_idx      <= '0;
          r_state    <= c_ST_LOAD;
        end
        c_ST_LOAD: begin
          r_vec[0] <= $signed(r_verts[int'(r_idx)*3*c_W +: c_W]);
          r_vec[1] <= $signed(r_verts[int'(r_idx)*3*c_W + c_W +: c_W]);
          r_vec[2] <= $signed(r_verts[int'(r_idx)*3*c_W + 2*c_W +: c_W]);
          r_vec[3] <= c_ONE;
          r_row    <= '0;
          r_state  <= c_ST_MAC;
        end
        c_ST_MAC: begin
          r_clip[r_row] <= w_row;
          r_row         <= r_row + 2'd1;
          if (r_row == 2'd3) r_state <= c_ST_CLIP;
        end
        c_ST_CLIP: if (w_clipped) begin
          clip_mask[r_idx] <= 1'b1;
          r_invw  <= '0;
          r_sx    <= '0;
          r_sy    <= '0;
          r_sz    <= '0;
          r_state <= c_ST_STORE;
        end else begin
          r_rem   <= c_DHI;
          r_dlo   <= c_DLO;
          r_quo   <= '0;
          r_ovf   <= c_DHI >= $unsigned(r_clip[3]);
          r_cnt   <= '0;
          r_state <= c_ST_DIV;
        end
        c_ST_DIV: begin
          r_rem <= w_rem_nx;
          r_quo <= {r_quo[c_W-2:0], w_ge};
          r_dlo <= r_dlo << 1;
          r_cnt <= r_cnt + c_CW'(1);
          if (r_cnt == c_CNT_LAST) r_state <= c_ST_NDC;
        end
        c_ST_NDC: begin
          r_invw  <= w_invw;
          r_nx    <= c_W'(w_px >>> c_F);
          r_ny    <= c_W'(w_py >>> c_F);
          r_nz    <= c_W'(w_pz >>> c_F);
          r_state <= c_ST_VIEW;
        end
        c_ST_VIEW: begin
          r_sx    <= w_vx;
          r_sy    <= w_vy;
          r_sz    <= w_vz;
          r_state <= c_ST_STORE;
        end
        c_ST_STORE: begin
          screen_out[int'(r_idx)*4*c_W +: 4*c_W] <= {r_invw, r_sz, r_sy, r_sx};
          if (r_idx == c_LAST) begin
`ifdef PROJECT_VERTICES_BACKFACE_CULL_EN
            if (|clip_mask[2:0]) begin
              done       <= 1'b1;
              busy       <= 1'b0;
              prim_valid <= ~|clip_mask;
              r_state    <= c_ST_DONE;
            end else begin
              r_state    <= c_ST_CULL0;
            end
`else
            done       <= 1'b1;
            busy       <= 1'b0;
            prim_valid <= ~|clip_mask;
            r_state    <= c_ST_DONE;
`endif
          end else begin
            r_idx   <= r_idx + c_IW'(1);
            r_state <= c_ST_LOAD;
          end
        end
`ifdef PROJECT_VERTICES_BACKFACE_CULL_EN
        c_ST_CULL0: r_state <= c_ST_CULL1;
        c_ST_CULL1: begin
          // Negative area is counter-clockwise on screen and survives.
          done       <= 1'b1;
          busy       <= 1'b0;
          prim_valid <= ~|clip_mask & (r_p1 < r_p2);
          r_state    <= c_ST_DONE;
        end
`endif
        c_ST_DONE: r_state <= c_ST_IDLE;
        default:   r_state <= c_ST_IDLE;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_project_vertices.sv
`default_nettype none
// ============================================================================
//  Module   : tb_project_vertices
//  Purpose  : Vector-table and scoreboard bench for project_vertices.
//  Revision : 1.0
// ============================================================================
module tb_project_vertices;
  localparam logic [31:0] ONE  = 32'h0001_0000;
  localparam logic [31:0] NONE = 32'hFFFF_0000;
  localparam logic [31:0] HALF = 32'h0000_8000;
  localparam logic [31:0] SMAX = 32'h7FFF_FFFF;
`ifdef PROJECT_VERTICES_BACKFACE_CULL_EN
  localparam int c_CULL    = 2;
  localparam bit c_CULL_ON = 1'b1;
`else
  localparam int c_CULL    = 0;
  localparam bit c_CULL_ON = 1'b0;
`endif

  typedef struct {
    logic [287:0] verts;
    logic [511:0] mvp;
    logic [383:0] scr;
    logic [2:0]   clip;
    logic         valid;
    int           lat;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0;
  logic [287:0] verts = '0;
  logic [511:0] mvp = '0;
  logic [383:0] scr;
  logic [2:0]   clip;
  logic         valid, busy, done;

  int   total = 0;
  int   bad = 0;
  vec_t tbl [5];
  vec_t exp_q [$];

  project_vertices dut (
    .clk_in     (clk),
    .rst_n_in   (rst_n),
    .start      (start),
    .verts_in   (verts),
    .mvp_in     (mvp),
    .screen_out (scr),
    .clip_mask  (clip),
    .prim_valid (valid),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  function automatic logic [511:0] mk_mvp(input logic [31:0] c0, c1, c2, c3);
    logic [511:0] m;
    m = '0;
    m[0*32 +: 32]  = ONE;
    m[5*32 +: 32]  = ONE;
    m[10*32 +: 32] = ONE;
    m[12*32 +: 32] = c0;
    m[13*32 +: 32] = c1;
    m[14*32 +: 32] = c2;
    m[15*32 +: 32] = c3;
    return m;
  endfunction

  function automatic logic [95:0] mkv(input logic [31:0] x, y, z);
    return {z, y, x};
  endfunction

  function automatic logic [127:0] mks(input logic [31:0] iw, z, y, x);
    return {iw, z, y, x};
  endfunction

  task automatic chk(input string name, input logic [383:0] act, input logic [383:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int restart_at, input bit start_in_done);
    int   cnt;
    bit   got;
    vec_t e;
    @(negedge clk);
    verts = v.verts;
    mvp   = v.mvp;
    start = 1'b1;
    exp_q.push_back(v);
    cnt = 0;
    got = 1'b0;
    while (!got && cnt < 400) begin
      @(posedge clk);
      cnt++;
      #1;
      start = (cnt == restart_at);
      if (cnt == 1) begin
        chk("busy_after_start", 384'(busy), 384'(1));
        chk("outputs_cleared", {scr, clip, valid}, '0);
      end
      if (done) got = 1'b1;
    end
    e = exp_q.pop_front();
    chk("done_latency", 384'(cnt), 384'(e.lat));
    chk("busy_at_done", 384'(busy), 384'(0));
    chk("clip_mask", 384'(clip), 384'(e.clip));
    chk("prim_valid", 384'(valid), 384'(e.valid));
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("screen_v%0d", i), 384'(scr[i*128 +: 128]), 384'(e.scr[i*128 +: 128]));
    end
    if (start_in_done) begin
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      chk("start_in_done_ignored", 384'(busy), 384'(0));
      @(posedge clk);
      #1;
      chk("idle_after_done", 384'({busy, done}), 384'(0));
    end else begin
      @(posedge clk);
      #1;
      chk("done_one_cycle", 384'(done), 384'(0));
    end
  endtask

  initial begin
    int nd;
    tbl[0] = '{verts: {mkv(NONE, HALF, ONE), mkv(ONE, ONE, 0), mkv(0, 0, 0)},
               mvp:   mk_mvp(0, 0, 0, ONE),
               scr:   {mks(ONE, ONE, 32'h002D_0000, 32'h0),
                       mks(ONE, HALF, 32'h0, 32'h0140_0000),
                       mks(ONE, HALF, 32'h005A_0000, 32'h00A0_0000)},
               clip: 3'b000, valid: 1'b1, lat: 124 + c_CULL};
    tbl[1] = '{verts: {mkv(32'h0002_0000, 0, 0), mkv(ONE, ONE, 0), mkv(0, 0, 0)},
               mvp:   mk_mvp(0, 0, 0, ONE),
               scr:   {128'h0,
                       mks(ONE, HALF, 32'h0, 32'h0140_0000),
                       mks(ONE, HALF, 32'h005A_0000, 32'h00A0_0000)},
               clip: 3'b100, valid: 1'b0, lat: 90};
    tbl[2] = '{verts: {mkv(0, 0, 0), mkv(0, 0, NONE), mkv(ONE, 0, 32'hFFFE_0000)},
               mvp:   mk_mvp(0, 0, NONE, 0),
               scr:   {128'h0,
                       mks(ONE, 32'h0, 32'h005A_0000, 32'h00A0_0000),
                       mks(HALF, 32'h0, 32'h005A_0000, 32'h00F0_0000)},
               clip: 3'b100, valid: 1'b0, lat: 90};
    tbl[3] = '{verts: {mkv(0, 0, 0), mkv(32'h1, 0, 0), mkv(0, 0, 0)},
               mvp:   mk_mvp(0, 0, 0, 32'h1),
               scr:   {mks(SMAX, HALF, 32'h005A_0000, 32'h00A0_0000),
                       mks(SMAX, HALF, 32'h005A_0000, 32'h00EF_FF60),
                       mks(SMAX, HALF, 32'h005A_0000, 32'h00A0_0000)},
               clip: 3'b000, valid: !c_CULL_ON, lat: 124 + c_CULL};
    tbl[4] = '{verts: {mkv(0, 0, 0), mkv(ONE, ONE, 0), mkv(0, 0, 0)},
               mvp:   mk_mvp(0, 0, 0, NONE),
               scr:   '0,
               clip: 3'b111, valid: 1'b0, lat: 22};

    #2 rst_n = 1'b0;
    #3;
    chk("reset_busy", 384'(busy), 384'(0));
    chk("reset_done", 384'(done), 384'(0));
    chk("reset_valid", 384'(valid), 384'(0));
    chk("reset_clip", 384'(clip), 384'(0));
    chk("reset_screen", scr, '0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    run_vec(tbl[0], 0, 1'b0);
    run_vec(tbl[1], 10, 1'b0);
    run_vec(tbl[2], 0, 1'b0);
    run_vec(tbl[3], 0, 1'b1);
    run_vec(tbl[4], 0, 1'b0);

    // Abort in the middle of the divide of vertex 0.
    @(negedge clk);
    verts = tbl[0].verts;
    mvp   = tbl[0].mvp;
    start = 1'b1;
    repeat (20) begin
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    chk("busy_before_abort", 384'(busy), 384'(1));
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 384'(busy), 384'(0));
    chk("abort_outputs", {scr, clip, valid, done}, '0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    nd = 0;
    repeat (150) begin
      @(posedge clk);
      #1;
      if (done) nd++;
    end
    chk("no_done_after_abort", 384'(nd), 384'(0));

    run_vec(tbl[0], 0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
